// File: rtl/ddr_cmd_addr_demux.sv
// ---------------------------------------------------------------------------
// ddr_cmd_addr_demux
// Memory-side DDR3 command/address monitor. Samples the command bus every
// clock, tracks the open row of each bank and rebuilds the full
// {bank,row,column} address for every READ/WRITE. Protocol violations are
// flagged on err/err_code.
//
// Optional feature macro: DDR_TRCD_CHECK_EN
//   When defined, a per-bank tRCD down-counter flags column commands issued
//   too soon after ACT. The access is still decoded.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cs_n/ras_n/cas_n/we_n  command strobes (active low)
//   ba, addr               bank address, multiplexed row/column address
//   acc_valid              1-cycle pulse, reconstructed access valid
//   acc_write/bank/row/col/ap  access payload (held while acc_valid=0)
//   err, err_code          1-cycle violation pulse; 1=ACT to open bank,
//                          2=column cmd to idle bank (or tRCD), 3=REF with
//                          a bank open
//   open_mask              bit b set while bank b is ACTIVE
// ---------------------------------------------------------------------------
module ddr_cmd_addr_demux #(
   parameter int ADDR_W = 12,
   parameter int BA_W   = 3,
   parameter int COL_W  = 10,
   parameter int TRCD   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cs_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 we_n,
   input  logic [BA_W-1:0]      ba,
   input  logic [ADDR_W-1:0]    addr,
   output logic                 acc_valid,
   output logic                 acc_write,
   output logic [BA_W-1:0]      acc_bank,
   output logic [ADDR_W-1:0]    acc_row,
   output logic [COL_W-1:0]     acc_col,
   output logic                 acc_ap,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [2**BA_W-1:0]   open_mask
);

   localparam int NB = 2**BA_W;

   // addr[10] is the A10 flag, so the row bus must reach it and columns
   // must stay below it.
   if (ADDR_W < 11 || COL_W > 10 || COL_W < 1 || TRCD < 1) begin : g_bad_param
      $error("ddr_cmd_addr_demux: illegal parameter combination");
   end

   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} bank_st_t;

   bank_st_t          r_st  [NB];
   logic [ADDR_W-1:0] r_row [NB];

   logic w_bank_open;
   logic w_any_open;

   always_comb begin
      open_mask = '0;
      for (int b = 0; b < NB; b++) open_mask[b] = (r_st[b] == ST_ACTIVE);
   end

   assign w_bank_open = (r_st[ba] == ST_ACTIVE);
   assign w_any_open  = |open_mask;

`ifdef DDR_TRCD_CHECK_EN
   localparam int CW = (TRCD > 2) ? $clog2(TRCD) : 1;
   logic [CW-1:0] r_trcd [NB];
   logic          w_trcd_busy;
   assign w_trcd_busy = (r_trcd[ba] != '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin
            r_st[b]  <= ST_IDLE;
            r_row[b] <= '0;
`ifdef DDR_TRCD_CHECK_EN
            r_trcd[b] <= '0;
`endif
         end
         acc_valid <= 1'b0;
         acc_write <= 1'b0;
         acc_bank  <= '0;
         acc_row   <= '0;
         acc_col   <= '0;
         acc_ap    <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         acc_valid <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
`ifdef DDR_TRCD_CHECK_EN
         for (int b = 0; b < NB; b++)
            if (r_trcd[b] != '0) r_trcd[b] <= r_trcd[b] - 1'b1;
`endif
         if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
               3'b011: begin                          // ACT
                  if (w_bank_open) begin
                     err      <= 1'b1;
                     err_code <= 2'd1;
                  end else begin
                     r_st[ba]  <= ST_ACTIVE;
                     r_row[ba] <= addr;
`ifdef DDR_TRCD_CHECK_EN
                     // Load overrides the decrement above for this bank.
                     r_trcd[ba] <= CW'(TRCD - 1);
`endif
                  end
               end
               3'b101, 3'b100: begin                  // READ / WRITE
                  if (w_bank_open) begin
                     acc_valid <= 1'b1;
                     acc_write <= ~we_n;
                     acc_bank  <= ba;
                     acc_row   <= r_row[ba];
                     acc_col   <= addr[COL_W-1:0];
                     acc_ap    <= addr[10];
                     if (addr[10]) r_st[ba] <= ST_IDLE;
`ifdef DDR_TRCD_CHECK_EN
                     if (w_trcd_busy) begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                     end
`endif
                  end else begin
                     err      <= 1'b1;
                     err_code <= 2'd2;
                  end
               end
               3'b010: begin                          // PRE / PRE-all
                  if (addr[10]) begin
                     for (int b = 0; b < NB; b++) r_st[b] <= ST_IDLE;
                  end else begin
                     r_st[ba] <= ST_IDLE;
                  end
               end
               3'b001: begin                          // REF
                  if (w_any_open) begin
                     err      <= 1'b1;
                     err_code <= 2'd3;
                  end
               end
               default: ;                             // NOP, MRS, ZQ
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ddr_cmd_addr_demux.sv
module tb_ddr_cmd_addr_demux;
   localparam int ADDR_W = 12;
   localparam int BA_W   = 3;
   localparam int COL_W  = 10;
   localparam int NB     = 8;

   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                          C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                          C_MRS = 4'b0000, C_ZQ  = 4'b0110;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [BA_W-1:0]   ba = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic              acc_valid, acc_write, acc_ap, err;
   logic [BA_W-1:0]   acc_bank;
   logic [ADDR_W-1:0] acc_row;
   logic [COL_W-1:0]  acc_col;
   logic [1:0]        err_code;
   logic [NB-1:0]     open_mask;

   ddr_cmd_addr_demux #(.ADDR_W(ADDR_W), .BA_W(BA_W), .COL_W(COL_W), .TRCD(4)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
      .we_n(we_n), .ba(ba), .addr(addr), .acc_valid(acc_valid),
      .acc_write(acc_write), .acc_bank(acc_bank), .acc_row(acc_row),
      .acc_col(acc_col), .acc_ap(acc_ap), .err(err), .err_code(err_code),
      .open_mask(open_mask));

   always #5 clk = ~clk;

   // {valid, write, bank, row, col, ap, err, code, mask}
   typedef logic [38:0] obs_t;

   typedef struct {
      string      name;
      logic [3:0] cmd;
      logic [2:0] ba;
      logic [11:0] addr;
      obs_t       exp;
   } vec_t;

   vec_t tbl[$];
   obs_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic obs_t pk(input logic v, input logic w, input logic [2:0] b,
                               input logic [11:0] row, input logic [9:0] col,
                               input logic ap, input logic e, input logic [1:0] code,
                               input logic [7:0] mask);
      return {v, w, b, row, col, ap, e, code, mask};
   endfunction

   function automatic obs_t actual();
      return {acc_valid, acc_write, acc_bank, acc_row, acc_col, acc_ap, err,
              err_code, open_mask};
   endfunction

   function automatic void add(input string name, input logic [3:0] cmd,
                               input logic [2:0] b, input logic [11:0] a, input obs_t exp);
      vec_t v;
      v.name = name; v.cmd = cmd; v.ba = b; v.addr = a; v.exp = exp;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got v=%b w=%b b=%0d row=%h col=%h ap=%b err=%b code=%0d mask=%h, expected v=%b w=%b b=%0d row=%h col=%h ap=%b err=%b code=%0d mask=%h",
                  name, got[38], got[37], got[36:34], got[33:22], got[21:12], got[11],
                  got[10], got[9:8], got[7:0], exp[38], exp[37], exp[36:34], exp[33:22],
                  exp[21:12], exp[11], exp[10], exp[9:8], exp[7:0]);
      end
   endtask

   // Drive one command on the falling edge, expect its result after the
   // next rising edge.
   task automatic step(input string name, input logic [3:0] cmd, input logic [2:0] b,
                       input logic [11:0] a, input obs_t exp);
      @(negedge clk);
      {cs_n, ras_n, cas_n, we_n} = cmd;
      ba = b; addr = a;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      chk(name, actual(), sb.pop_front());
   endtask

   initial begin
      // ---------------- vector table ----------------
      add("act2",   C_ACT, 2, 12'h3A5, pk(0,0,0,12'h000,10'h000,0,0,0,8'h04));
      for (int i = 0; i < 4; i++)
         add("nop_a", C_NOP, 0, 12'h000, pk(0,0,0,12'h000,10'h000,0,0,0,8'h04));
      add("rd2",    C_RD,  2, 12'h07F, pk(1,0,2,12'h3A5,10'h07F,0,0,0,8'h04));
      add("hold1",  C_NOP, 0, 12'h000, pk(0,0,2,12'h3A5,10'h07F,0,0,0,8'h04));
      add("act5",   C_ACT, 5, 12'h0F0, pk(0,0,2,12'h3A5,10'h07F,0,0,0,8'h24));
      for (int i = 0; i < 3; i++)
         add("nop_b", C_NOP, 0, 12'h000, pk(0,0,2,12'h3A5,10'h07F,0,0,0,8'h24));
      add("wr5ap",  C_WR,  5, 12'h412, pk(1,1,5,12'h0F0,10'h012,1,0,0,8'h04));
      add("rd5idle",C_RD,  5, 12'h000, pk(0,1,5,12'h0F0,10'h012,1,1,2,8'h04));
      add("errclr", C_NOP, 0, 12'h000, pk(0,1,5,12'h0F0,10'h012,1,0,0,8'h04));
      add("act1",   C_ACT, 1, 12'h111, pk(0,1,5,12'h0F0,10'h012,1,0,0,8'h06));
      add("act1dup",C_ACT, 1, 12'h222, pk(0,1,5,12'h0F0,10'h012,1,1,1,8'h06));
      for (int i = 0; i < 3; i++)
         add("nop_c", C_NOP, 0, 12'h000, pk(0,1,5,12'h0F0,10'h012,1,0,0,8'h06));
      add("rd1",    C_RD,  1, 12'h005, pk(1,0,1,12'h111,10'h005,0,0,0,8'h06));
      add("pre1",   C_PRE, 1, 12'h000, pk(0,0,1,12'h111,10'h005,0,0,0,8'h04));
      add("pre2",   C_PRE, 2, 12'h000, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("pre2idle",C_PRE,2, 12'h000, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("act0",   C_ACT, 0, 12'h0AA, pk(0,0,1,12'h111,10'h005,0,0,0,8'h01));
      add("act3",   C_ACT, 3, 12'h033, pk(0,0,1,12'h111,10'h005,0,0,0,8'h09));
      add("ref_open",C_REF,0, 12'h000, pk(0,0,1,12'h111,10'h005,0,1,3,8'h09));
      add("preall", C_PRE, 5, 12'h400, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("ref_ok", C_REF, 0, 12'h000, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("des_act",4'b1011,4,12'h055, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("des_rd", 4'b1101,1,12'h055, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("mrs",    C_MRS, 0, 12'h123, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("zq",     C_ZQ,  0, 12'h400, pk(0,0,1,12'h111,10'h005,0,0,0,8'h00));
      add("act7",   C_ACT, 7, 12'hFFF, pk(0,0,1,12'h111,10'h005,0,0,0,8'h80));
      for (int i = 0; i < 3; i++)
         add("nop_d", C_NOP, 0, 12'h000, pk(0,0,1,12'h111,10'h005,0,0,0,8'h80));
      add("rd7max", C_RD,  7, 12'hBFF, pk(1,0,7,12'hFFF,10'h3FF,0,0,0,8'h80));
      add("wr7ap",  C_WR,  7, 12'hFFF, pk(1,1,7,12'hFFF,10'h3FF,1,0,0,8'h00));
      add("hold7",  C_NOP, 0, 12'h000, pk(0,1,7,12'hFFF,10'h3FF,1,0,0,8'h00));

      // ---------------- reset state ----------------
      #12;
      chk("reset_state", actual(), '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i].name, tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].exp);

      // ---------------- asynchronous reset with banks open ----------------
      step("act4", C_ACT, 4, 12'h123, pk(0,1,7,12'hFFF,10'h3FF,1,0,0,8'h10));
      step("act6pre", C_ACT, 6, 12'h321, pk(0,1,7,12'hFFF,10'h3FF,1,0,0,8'h50));
      @(negedge clk);
      {cs_n, ras_n, cas_n, we_n} = C_NOP;
      #2;
      rst_n = 1'b0;
      #1;  // still before the next rising edge
      chk("async_reset", actual(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      step("rd_after_rst", C_RD, 4, 12'h010, pk(0,0,0,12'h000,10'h000,0,1,2,8'h00));

      // ---------------- tRCD window ----------------
      step("act6", C_ACT, 6, 12'h010, pk(0,0,0,12'h000,10'h000,0,0,0,8'h40));
      step("nop_e", C_NOP, 0, 12'h000, pk(0,0,0,12'h000,10'h000,0,0,0,8'h40));
`ifdef DDR_TRCD_CHECK_EN
      step("rd6_early", C_RD, 6, 12'h001, pk(1,0,6,12'h010,10'h001,0,1,2,8'h40));
`else
      step("rd6_early", C_RD, 6, 12'h001, pk(1,0,6,12'h010,10'h001,0,0,0,8'h40));
`endif
      step("nop_f", C_NOP, 0, 12'h000, pk(0,0,6,12'h010,10'h001,0,0,0,8'h40));
      step("pre6", C_PRE, 6, 12'h000, pk(0,0,6,12'h010,10'h001,0,0,0,8'h00));
      step("act6b", C_ACT, 6, 12'h020, pk(0,0,6,12'h010,10'h001,0,0,0,8'h40));
      for (int i = 0; i < 3; i++)
         step("nop_g", C_NOP, 0, 12'h000, pk(0,0,6,12'h010,10'h001,0,0,0,8'h40));
      step("rd6_ok", C_RD, 6, 12'h002, pk(1,0,6,12'h020,10'h002,0,0,0,8'h40));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
